pc_redirect_seq: RTL and testbench

- Fetch-stage PC sequencer; consumes the branch-taken decision produced in the D stage (branch-type decode ANDed with comparator result), plus J/JAL and JR/JALR requests.
- Owns the F-stage PC register.
- Implements the MIPS single delay slot, hazard stalls, and a fetch-ready handshake with instruction memory.
- Buffers a redirect whose delay slot has not yet been fetched.

---
 rtl/pc_redirect_seq.sv | 113 +++++++++++
 tb/tb_pc_redirect_seq.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/pc_redirect_seq.sv
// Fetch-stage PC sequencer: owns pc_f, applies J/JR/branch redirects after the MIPS delay slot,
// and buffers a redirect until its delay slot has been fetched. Optional counters: PC_REDIRECT_STATS_EN.
module pc_redirect_seq #(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_3000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            if_ready,
  input  logic            d_valid,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_target,
  input  logic            j_req,
  input  logic [PC_W-1:0] j_target,
  input  logic            jr_req,
  input  logic [PC_W-1:0] jr_target,
  output logic [PC_W-1:0] pc_f,
  output logic            f_valid,
  output logic            pending,
  output logic            adel_f
`ifdef PC_REDIRECT_STATS_EN
  ,
  output logic [31:0]     redir_cnt,
  output logic [31:0]     pend_cnt
`endif
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_PEND = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pend_target_q, pend_target_d;
  logic            advance;
  logic            redir;
  logic [PC_W-1:0] tgt;

  assign advance = if_ready & ~stall;
  assign redir   = d_valid & ~stall & (jr_req | j_req | br_taken);
  assign tgt     = jr_req ? jr_target : (j_req ? j_target : br_target);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_target_d = pend_target_q;
    case (state_q)
      ST_RUN: begin
        if (redir) begin
          // The word at the old pc_f is the delay slot; only jump once it has been taken.
          if (if_ready) begin
            pc_d = tgt;
          end else begin
            pend_target_d = tgt;
            state_d       = ST_PEND;
          end
        end else if (advance) begin
          pc_d = pc_q + PC_W'(4);
        end
      end
      ST_PEND: begin
        // D only holds a bubble here, so any redir seen now is spurious and ignored.
        if (advance) begin
          pc_d    = pend_target_q;
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      pc_q          <= RESET_PC;
      pend_target_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_target_q <= pend_target_d;
    end
  end

`ifdef PC_REDIRECT_STATS_EN
  logic [31:0] redir_cnt_q;
  logic [31:0] pend_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      redir_cnt_q <= '0;
      pend_cnt_q  <= '0;
    end else begin
      if (state_q == ST_RUN && redir) begin
        redir_cnt_q <= redir_cnt_q + 32'd1;
      end
      if (state_q == ST_PEND) begin
        pend_cnt_q <= pend_cnt_q + 32'd1;
      end
    end
  end

  assign redir_cnt = redir_cnt_q;
  assign pend_cnt  = pend_cnt_q;
`endif

  assign pc_f    = pc_q;
  assign f_valid = advance;
  assign pending = (state_q == ST_PEND);
  assign adel_f  = (pc_q[1:0] != 2'b00);

endmodule

// File: tb/tb_pc_redirect_seq.sv
// Self-checking bench for pc_redirect_seq: directed scenarios followed by random traffic,
// compared each cycle against a behavioural model of the fetch PC.
module tb_pc_redirect_seq;

  localparam logic [31:0] RST_PC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, if_ready, d_valid, br_taken, j_req, jr_req;
  logic [31:0] br_target, j_target, jr_target;
  logic [31:0] pc_f;
  logic        f_valid, pending, adel_f;
`ifdef PC_REDIRECT_STATS_EN
  logic [31:0] redir_cnt, pend_cnt;
  logic [31:0] m_rcnt, m_pcnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: where fetch is, and whether a jump is waiting for its delay slot.
  logic [31:0] m_pc;
  bit          m_wait;
  logic [31:0] m_dest;

  pc_redirect_seq #(.PC_W(32), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .if_ready(if_ready), .d_valid(d_valid),
    .br_taken(br_taken), .br_target(br_target), .j_req(j_req), .j_target(j_target),
    .jr_req(jr_req), .jr_target(jr_target), .pc_f(pc_f), .f_valid(f_valid),
    .pending(pending), .adel_f(adel_f)
`ifdef PC_REDIRECT_STATS_EN
    , .redir_cnt(redir_cnt), .pend_cnt(pend_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_ctrl();
    stall = 0; d_valid = 0; br_taken = 0; j_req = 0; jr_req = 0;
  endtask

  function automatic logic [31:0] rand_tgt();
    case ($urandom_range(0, 3))
      0: return $urandom;
      1: return {$urandom, 2'b00} ;
      2: return 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      default: return 32'h0000_3000 + 32'($urandom_range(0, 63) * 4);
    endcase
  endfunction

  // One clock: check current outputs against the model, then advance both.
  task automatic step();
    bit          go, jump;
    logic [31:0] dest;
    #2;
    go   = if_ready && !stall;
    jump = d_valid && !stall && (jr_req || j_req || br_taken);
    dest = jr_req ? jr_target : (j_req ? j_target : br_target);
    check("pc_f",    pc_f,    m_pc);
    check("f_valid", 32'(f_valid), 32'(go));
    check("pending", 32'(pending), 32'(m_wait));
    check("adel_f",  32'(adel_f),  32'(m_pc[1:0] != 2'b00));
`ifdef PC_REDIRECT_STATS_EN
    check("redir_cnt", redir_cnt, m_rcnt);
    check("pend_cnt",  pend_cnt,  m_pcnt);
`endif
    @(posedge clk);
    if (!rst_n) begin
      m_pc = RST_PC; m_wait = 0; m_dest = 0;
`ifdef PC_REDIRECT_STATS_EN
      m_rcnt = 0; m_pcnt = 0;
`endif
    end else if (m_wait) begin
`ifdef PC_REDIRECT_STATS_EN
      m_pcnt++;
`endif
      if (go) begin m_pc = m_dest; m_wait = 0; end
    end else begin
`ifdef PC_REDIRECT_STATS_EN
      if (jump) m_rcnt++;
`endif
      if (jump && if_ready)  m_pc = dest;
      else if (jump)         begin m_wait = 1; m_dest = dest; end
      else if (go)           m_pc = m_pc + 32'd4;
    end
    #1;
  endtask

  initial begin
    rst_n = 0; if_ready = 0; clear_ctrl();
    br_target = 0; j_target = 0; jr_target = 0;
    repeat (2) @(posedge clk);
    #1;
    m_pc = RST_PC; m_wait = 0; m_dest = 0;
`ifdef PC_REDIRECT_STATS_EN
    m_rcnt = 0; m_pcnt = 0;
`endif
    check("rst_pc", pc_f, RST_PC);
    check("rst_pending", 32'(pending), 32'd0);

    // Sequential fetch
    rst_n = 1; if_ready = 1;
    repeat (3) step();
    check("seq_pc", pc_f, 32'h0000_300C);
    step();

    // Taken branch with delay slot fetched in the same cycle
    d_valid = 1; br_taken = 1; br_target = 32'h0000_3100;
    step(); clear_ctrl();
    check("br_pc", pc_f, 32'h0000_3100);

    d_valid = 1; jr_req = 1; jr_target = 32'h0000_3020;
    step(); clear_ctrl();

    // Jump while imem is not ready: buffered until the delay slot arrives
    if_ready = 0; d_valid = 1; j_req = 1; j_target = 32'h0000_3400;
    step(); clear_ctrl();
    step();
    check("pend_flag", 32'(pending), 32'd1);
    check("pend_hold", pc_f, 32'h0000_3020);
    if_ready = 1;
    step();
    check("pend_pc", pc_f, 32'h0000_3400);
    check("pend_clr", 32'(pending), 32'd0);

    // jr beats br
    d_valid = 1; jr_req = 1; jr_target = 32'h0000_3500; br_taken = 1; br_target = 32'h0000_3600;
    step(); clear_ctrl();
    check("prio_pc", pc_f, 32'h0000_3500);

    // Stall holds the redirect until released
    stall = 1; d_valid = 1; br_taken = 1; br_target = 32'h0000_3700;
    repeat (3) step();
    check("stall_pc", pc_f, 32'h0000_3500);
    stall = 0;
    step(); clear_ctrl();
    check("unstall_pc", pc_f, 32'h0000_3700);

    // Reset while pending
    if_ready = 0; d_valid = 1; j_req = 1; j_target = 32'h0000_3800;
    step(); clear_ctrl();
    check("pre_rst_pend", 32'(pending), 32'd1);
    rst_n = 0;
    step();
    rst_n = 1;
    check("pend_rst_pc", pc_f, RST_PC);
    check("pend_rst_flag", 32'(pending), 32'd0);

    // Misaligned target
    if_ready = 1; d_valid = 1; jr_req = 1; jr_target = 32'h0000_3502;
    step(); clear_ctrl();
    check("adel_pc", pc_f, 32'h0000_3502);
    check("adel_f", 32'(adel_f), 32'd1);

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      rst_n     = ($urandom_range(0, 99) != 0);
      stall     = ($urandom_range(0, 3) == 0);
      if_ready  = ($urandom_range(0, 2) != 0);
      d_valid   = $urandom_range(0, 1) == 1;
      br_taken  = ($urandom_range(0, 3) == 0);
      j_req     = ($urandom_range(0, 4) == 0);
      jr_req    = ($urandom_range(0, 4) == 0);
      br_target = rand_tgt();
      j_target  = rand_tgt();
      jr_target = rand_tgt();
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
